// File: rtl/pll_rst_seq.sv
// PLL supervisor and staggered reset sequencer: pulses the PLL reset, qualifies lock, releases
// N_OUT reset domains in order. Define PLL_RST_SEQ_RETRY_EN to re-pulse the PLL on lock timeout.
module pll_rst_seq #(
  parameter int N_OUT          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_CYCLES    = 1024,
  parameter int STAGGER        = 16,
  parameter int LOCK_TIMEOUT   = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             sw_rst,
  output logic             pll_rst,
  output logic [N_OUT-1:0] rst_out,
  output logic             ready,
  output logic [7:0]       lock_loss_cnt
);

`ifdef PLL_RST_SEQ_RETRY_EN
  localparam int TIMEOUT_MAX = LOCK_TIMEOUT;
`else
  localparam int TIMEOUT_MAX = 0 * LOCK_TIMEOUT;
`endif

  // One counter is shared: each state uses it for its own purpose and clears it on exit.
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_CYCLES) ? PLL_RST_CYCLES : LOCK_CYCLES;
  localparam int MAX_B   = (STAGGER > TIMEOUT_MAX) ? STAGGER : TIMEOUT_MAX;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(N_OUT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGGER - 1);
`ifdef PLL_RST_SEQ_RETRY_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
`endif
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [N_OUT-1:0]       rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;
  logic [7:0]             lock_loss_cnt_q, lock_loss_cnt_d;
  logic [N_OUT-1:0]       clr_mask;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // idx_q names the next domain to release; clr_mask is its one-hot select.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_clr
    assign clr_mask[gi] = (idx_q == IDX_W'(gi));
  end

  always_comb begin
    sync_d          = {sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    pll_rst_d       = 1'b0;
    rst_out_d       = '1;
    ready_d         = 1'b0;
    lock_loss_cnt_d = lock_loss_cnt_q;

    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          pll_rst_d = 1'b1;
          cnt_d     = cnt_q + CNT_ONE;
        end
      end

      S_WAIT_LOCK: begin
        // The cycle that first sees lock is itself the first counted stable cycle.
        if (locked_s) begin
          if (LOCK_CYCLES == 1) begin
            state_d      = S_RELEASE;
            cnt_d        = '0;
            idx_d        = IDX_ONE;
            rst_out_d[0] = 1'b0;
          end else begin
            state_d = S_STABLE;
            cnt_d   = CNT_ONE;
          end
        end
`ifdef PLL_RST_SEQ_RETRY_EN
        else if (cnt_q == TO_LAST) begin
          state_d   = S_RESET_PLL;
          cnt_d     = CNT_ONE;
          pll_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end

      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (sw_rst) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d      = S_RELEASE;
          cnt_d        = '0;
          idx_d        = IDX_ONE;
          rst_out_d[0] = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RELEASE, S_RUN: begin
        // Lock loss outranks a simultaneous software request.
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
          if (lock_loss_cnt_q != 8'hFF) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
          end
        end else if (sw_rst) begin
          state_d = S_STABLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (state_q == S_RUN) begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end else begin
          rst_out_d = rst_out_q;
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else if (cnt_q == STG_LAST) begin
            cnt_d     = '0;
            idx_d     = idx_q + IDX_ONE;
            rst_out_d = rst_out_q & ~clr_mask;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d   = S_RESET_PLL;
        cnt_d     = '0;
        idx_d     = '0;
        pll_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_RESET_PLL;
      cnt_q           <= '0;
      idx_q           <= '0;
      sync_q          <= '0;
      pll_rst_q       <= 1'b1;
      rst_out_q       <= '1;
      ready_q         <= 1'b0;
      lock_loss_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      sync_q          <= sync_d;
      pll_rst_q       <= pll_rst_d;
      rst_out_q       <= rst_out_d;
      ready_q         <= ready_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign rst_out       = rst_out_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: constant vector table, hand sequences and random stimulus against a
// timestamp-based reference model. Build with PLL_RST_SEQ_RETRY_EN to cover the lock timeout.
`timescale 1ns/1ps
module tb_pll_rst_seq;
  localparam int N_OUT          = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int PLL_RST_CYCLES = 8;
  localparam int LOCK_CYCLES    = 16;
  localparam int STAGGER        = 4;
  localparam int LOCK_TIMEOUT   = 64;
  localparam int OW             = N_OUT + 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pll_locked = 1'b0;
  logic             sw_rst = 1'b0;
  logic             pll_rst;
  logic [N_OUT-1:0] rst_out;
  logic             ready;
  logic [7:0]       lock_loss_cnt;

  int checks = 0;
  int failures = 0;
  int hold = 0;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .N_OUT(N_OUT), .SYNC_STAGES(SYNC_STAGES), .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_CYCLES(LOCK_CYCLES), .STAGGER(STAGGER), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_rst(sw_rst),
    .pll_rst(pll_rst), .rst_out(rst_out), .ready(ready), .lock_loss_cnt(lock_loss_cnt)
  );

  // Reference model: phases plus edge timestamps; outputs derived from time since release.
  typedef enum {PH_PLLRST, PH_WAIT, PH_COUNT, PH_REL} phase_e;
  phase_e ph;
  int     n, rst_end, wait_start, release_at, rel_edge, m_losses;
  bit     hist[$];

  function void model_reset();
    ph = PH_PLLRST; n = -1; rst_end = PLL_RST_CYCLES; wait_start = 0;
    release_at = 0; rel_edge = 0; m_losses = 0;
    hist = {};
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
  endfunction

  function void model_edge(input bit pl, input bit sw);
    bit ls;
    n++;
    ls = hist.pop_front();
    hist.push_back(pl);
    case (ph)
      PH_PLLRST: if (n >= rst_end) begin ph = PH_WAIT; wait_start = n; end
      PH_WAIT: begin
        if (ls) begin
          release_at = n + LOCK_CYCLES - 1;
          ph = PH_COUNT;
          if (release_at == n) begin ph = PH_REL; rel_edge = n; end
        end
`ifdef PLL_RST_SEQ_RETRY_EN
        else if (n - wait_start >= LOCK_TIMEOUT) begin
          ph = PH_PLLRST; rst_end = n + PLL_RST_CYCLES;
        end
`endif
      end
      PH_COUNT: begin
        if (!ls) begin ph = PH_WAIT; wait_start = n; end
        else if (sw) release_at = n + LOCK_CYCLES;
        else if (n == release_at) begin ph = PH_REL; rel_edge = n; end
      end
      PH_REL: begin
        if (!ls) begin
          ph = PH_WAIT; wait_start = n;
          if (m_losses < 255) m_losses++;
        end else if (sw) begin
          ph = PH_COUNT; release_at = n + LOCK_CYCLES;
        end
      end
      default: ph = PH_PLLRST;
    endcase
  endfunction

  function logic [OW-1:0] model_out();
    logic [N_OUT-1:0] r;
    logic             rdy;
    for (int i = 0; i < N_OUT; i++) r[i] = !(ph == PH_REL && n >= rel_edge + i * STAGGER);
    rdy = (ph == PH_REL) && (n >= rel_edge + (N_OUT - 1) * STAGGER + 1);
    return {ph == PH_PLLRST, r, rdy, 8'(m_losses)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, n, act, exp);
    end
  endtask

  task automatic step(input int k);
    for (int j = 0; j < k; j++) begin
      bit pl, sw;
      pl = pll_locked;
      sw = sw_rst;
      @(posedge clk);
      model_edge(pl, sw);
      #1;
      check("model", {pll_rst, rst_out, ready, lock_loss_cnt}, model_out());
    end
  endtask

  typedef struct {
    int         wait_n;
    bit         pl;
    bit         sw;
    logic       pr;
    logic [3:0] ro;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;
  vec_t vecs[$];

  function void add(input int w, input bit pl, input bit sw, input logic pr,
                    input logic [3:0] ro, input logic rdy, input int cnt);
    vec_t v;
    v.wait_n = w; v.pl = pl; v.sw = sw; v.pr = pr; v.ro = ro; v.rdy = rdy; v.cnt = 8'(cnt);
    vecs.push_back(v);
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog cycle=%0d", n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // cycle index after the final edge of each entry noted on the right
    add(8,  0, 0, 1, 4'hF, 0, 0);  // 7
    add(1,  0, 0, 0, 4'hF, 0, 0);  // 8
    add(12, 0, 0, 0, 4'hF, 0, 0);  // 20: lock rises after this edge
    add(17, 1, 0, 0, 4'hF, 0, 0);  // 37
    add(1,  1, 0, 0, 4'hE, 0, 0);  // 38
    add(3,  1, 0, 0, 4'hE, 0, 0);  // 41
    add(1,  1, 0, 0, 4'hC, 0, 0);  // 42
    add(4,  1, 0, 0, 4'h8, 0, 0);  // 46
    add(4,  1, 0, 0, 4'h0, 0, 0);  // 50
    add(1,  1, 0, 0, 4'h0, 1, 0);  // 51
    add(5,  1, 0, 0, 4'h0, 1, 0);  // 56
    add(1,  0, 0, 0, 4'h0, 1, 0);  // 57: one-cycle lock drop
    add(1,  1, 0, 0, 4'h0, 1, 0);  // 58
    add(1,  1, 0, 0, 4'hF, 0, 1);  // 59
    add(15, 1, 0, 0, 4'hF, 0, 1);  // 74
    add(1,  1, 0, 0, 4'hE, 0, 1);  // 75
    add(12, 1, 0, 0, 4'h0, 0, 1);  // 87
    add(1,  1, 0, 0, 4'h0, 1, 1);  // 88
    add(1,  1, 1, 0, 4'hF, 0, 1);  // 89: sw_rst pulse
    add(15, 1, 0, 0, 4'hF, 0, 1);  // 104
    add(1,  1, 0, 0, 4'hE, 0, 1);  // 105
    add(13, 1, 0, 0, 4'h0, 1, 1);  // 118
    add(1,  1, 1, 0, 4'hF, 0, 1);  // 119: back into STABLE
    add(3,  1, 0, 0, 4'hF, 0, 1);  // 122
    add(1,  0, 0, 0, 4'hF, 0, 1);  // 123: glitch during STABLE
    add(17, 1, 0, 0, 4'hF, 0, 1);  // 140
    add(1,  1, 0, 0, 4'hE, 0, 1);  // 141
    add(13, 1, 0, 0, 4'h0, 1, 1);  // 154
    add(2,  0, 0, 0, 4'h0, 1, 1);  // 156
    add(1,  0, 1, 0, 4'hF, 0, 2);  // 157: loss and sw_rst together
    add(10, 0, 0, 0, 4'hF, 0, 2);  // 167

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset", {pll_rst, rst_out, ready, lock_loss_cnt}, {1'b1, 4'hF, 1'b0, 8'h00});
    $display("reset values pll_rst=%b rst_out=%h ready=%b cnt=%0d", pll_rst, rst_out, ready, lock_loss_cnt);
    rst_n = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      pll_locked = vecs[v].pl;
      sw_rst     = vecs[v].sw;
      step(vecs[v].wait_n);
      check("vec", {pll_rst, rst_out, ready, lock_loss_cnt},
            {vecs[v].pr, vecs[v].ro, vecs[v].rdy, vecs[v].cnt});
      $display("vec %0d cycle=%0d pll_rst=%b rst_out=%h ready=%b cnt=%0d", v, n, pll_rst, rst_out,
               ready, lock_loss_cnt);
    end
    sw_rst = 1'b0;

    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        if (hold == 0) begin
          pll_locked = ($urandom_range(0, 3) != 0);
          hold = pll_locked ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 6));
        end else begin
          hold--;
        end
        sw_rst = ($urandom_range(0, 63) == 0);
        step(1);
      end
      $display("random segment %0d cycle=%0d losses=%0d", seg, n, m_losses);
    end
    sw_rst = 1'b0;

    for (int k = 0; k < 260; k++) begin
      int budget;
      budget = 0;
      pll_locked = 1'b1;
      while (rst_out[0] !== 1'b0 && budget < 60) begin
        step(1);
        budget++;
      end
      check("release_wait", {31'b0, rst_out[0]}, 32'd0);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(3);
    end
    check("loss_sat", {24'b0, lock_loss_cnt}, 32'd255);
    $display("saturation cycle=%0d lock_loss_cnt=%0d", n, lock_loss_cnt);

    begin
      int budget;
      budget = 0;
      pll_locked = 1'b1;
      while (rst_out !== 4'hE && budget < 60) begin
        step(1);
        budget++;
      end
      check("reach_release", {28'b0, rst_out}, 32'hE);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst", {pll_rst, rst_out, ready, lock_loss_cnt}, {1'b1, 4'hF, 1'b0, 8'h00});
      check("async_rst_model", {pll_rst, rst_out, ready, lock_loss_cnt}, model_out());
      $display("async reset mid-release pll_rst=%b rst_out=%h ready=%b cnt=%0d", pll_rst, rst_out,
               ready, lock_loss_cnt);
      pll_locked = 1'b0;
      @(posedge clk);
      #1;
      check("rst_held", {pll_rst, rst_out, ready, lock_loss_cnt}, {1'b1, 4'hF, 1'b0, 8'h00});
      rst_n = 1'b1;
    end

    for (int c = 0; c < 160; c++) begin
      logic exp_pr;
      step(1);
`ifdef PLL_RST_SEQ_RETRY_EN
      exp_pr = (n < 8) || (n >= 72 && n < 80) || (n >= 144 && n < 152);
`else
      exp_pr = (n < 8);
`endif
      check("pll_rst_pattern", {31'b0, pll_rst}, {31'b0, exp_pr});
    end
    $display("no-lock sequence cycle=%0d pll_rst=%b rst_out=%h", n, pll_rst, rst_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
